// File: rtl/secded_decode_pipe_if.sv
// Stream bundle for the SEC-DED decoder: received word + check bits in, decoded word + syndrome/flags out.
// master drives the input word and out_ready; slave (the decoder) drives in_ready and the decoded result.
interface secded_decode_pipe_if #(
  parameter int DATA_W = 16,
  parameter int R      = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [R:0]        in_check;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [R-1:0]      out_syn;
  logic              out_sec;
  logic              out_ded;

  modport master (
    output in_valid, in_data, in_check, out_ready,
    input  in_ready, out_valid, out_data, out_syn, out_sec, out_ded
  );

  modport slave (
    input  in_valid, in_data, in_check, out_ready,
    output in_ready, out_valid, out_data, out_syn, out_sec, out_ded
  );
endinterface

// File: rtl/secded_decode_pipe.sv
// Pipelined SEC-DED (extended Hamming) decoder with saturating error counters; 2-cycle latency, 1 word/cycle.
// A stage loads when empty or when its successor drains; in_ready drops only with both stages full and out_ready low.
module secded_decode_pipe #(
  parameter int DATA_W = 16,
  parameter int R      = 5,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  secded_decode_pipe_if.slave io,
  input  logic                cfg_correct,
  input  logic                cnt_clr,
  output logic [CNT_W-1:0]    sec_cnt,
  output logic [CNT_W-1:0]    ded_cnt
);
  localparam int N    = DATA_W + R;
  localparam bit R_OK = (DATA_W >= 4) && ((1 << R) >= N + 1) && ((1 << (R - 1)) < N + 1);

  // Codeword position of data bit j: the j-th position that is not a power of two.
  function automatic int data_pos(int j);
    int p;
    int k;
    p = 0;
    k = -1;
    while (k < j) begin
      p = p + 1;
      if ((p & (p - 1)) != 0) k = k + 1;
    end
    return p;
  endfunction

  logic [DATA_W-1:0][R-1:0] dsyn;
  logic [DATA_W-1:0]        flip;
  logic [R-1:0]             syn_c;
  logic                     p_c;

  logic                     s1_vld;
  logic [DATA_W-1:0]        s1_dat;
  logic [R-1:0]             s1_syn;
  logic                     s1_p;
  logic                     s1_cor;

  logic                     s2_vld;
  logic [DATA_W-1:0]        s2_dat;
  logic [R-1:0]             s2_syn;
  logic                     s2_sec;
  logic                     s2_ded;

  logic                     s1_en;
  logic                     s2_en;
  logic                     fire;
  logic                     pow2;
  logic                     in_range;
  logic                     is_sec;
  logic                     is_ded;
  logic [DATA_W-1:0]        cor_dat;

  // The syndrome equals the XOR of the positions of all set codeword bits; check bit i sits at 2^i.
  for (genvar j = 0; j < DATA_W; j++) begin : g_pos
    localparam logic [R-1:0] POS = R'(data_pos(j));
    assign dsyn[j] = io.in_data[j] ? POS : '0;
    assign flip[j] = (s1_syn == POS);
  end

  always_comb begin
    syn_c = io.in_check[R-1:0];
    for (int j = 0; j < DATA_W; j++) syn_c = syn_c ^ dsyn[j];
  end

  assign p_c = ^{io.in_data, io.in_check};

  always_comb begin
    pow2     = (s1_syn & (s1_syn - R'(1))) == '0;
    in_range = int'(s1_syn) <= N;
    is_sec   = s1_p & (pow2 | in_range);
    is_ded   = s1_p ? !(pow2 | in_range) : (s1_syn != '0);
    cor_dat  = (s1_p & s1_cor) ? (s1_dat ^ flip) : s1_dat;
  end

  assign s2_en       = !s2_vld | io.out_ready;
  assign s1_en       = !s1_vld | s2_en;
  assign io.in_ready = s1_en;
  assign fire        = s2_vld & io.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_dat <= '0;
      s1_syn <= '0;
      s1_p   <= 1'b0;
      s1_cor <= 1'b0;
    end else if (s1_en) begin
      s1_vld <= io.in_valid;
      if (io.in_valid) begin
        s1_dat <= io.in_data;
        s1_syn <= syn_c;
        s1_p   <= p_c;
        s1_cor <= cfg_correct;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld <= 1'b0;
      s2_dat <= '0;
      s2_syn <= '0;
      s2_sec <= 1'b0;
      s2_ded <= 1'b0;
    end else if (s2_en) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_dat <= cor_dat;
        s2_syn <= s1_syn;
        s2_sec <= is_sec;
        s2_ded <= is_ded;
      end
    end
  end

  assign io.out_valid = s2_vld;
  assign io.out_data  = s2_dat;
  assign io.out_syn   = s2_syn;
  assign io.out_sec   = s2_sec;
  assign io.out_ded   = s2_ded;

  // Clear has priority over a same-cycle delivery.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      sec_cnt <= '0;
      ded_cnt <= '0;
    end else if (fire) begin
      if (s2_sec && sec_cnt != '1) sec_cnt <= sec_cnt + CNT_W'(1);
      if (s2_ded && ded_cnt != '1) ded_cnt <= ded_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (R_OK);
  end
endmodule

// File: tb/tb_secded_decode_pipe.sv
// Directed + randomized bench for secded_decode_pipe against a spec-level encode/classify model.
module tb_secded_decode_pipe;
  localparam int DW   = 16;
  localparam int RW   = 5;
  localparam int CW   = 2;
  localparam int N    = DW + RW;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic [DW-1:0] dat;
    logic [RW-1:0] syn;
    logic          sec;
    logic          ded;
  } exp_t;

  typedef struct {
    exp_t e;
    int   acc;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_correct = 1'b0;
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] sec_cnt;
  logic [CW-1:0] ded_cnt;

  secded_decode_pipe_if #(.DATA_W(DW), .R(RW)) bus ();

  secded_decode_pipe #(.DATA_W(DW), .R(RW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .io         (bus),
    .cfg_correct(cfg_correct),
    .cnt_clr    (cnt_clr),
    .sec_cnt    (sec_cnt),
    .ded_cnt    (ded_cnt)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   cyc_n = 0;
  int   sec_m = 0;
  int   ded_m = 0;
  bit   strict = 1'b0;
  bit   stalled = 1'b0;
  bit   acc_flag = 1'b0;
  exp_t last;
  ent_t q[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Data bit j occupies the j-th non-power-of-two position, counting from 1.
  function automatic int dpos(int j);
    int k = 0;
    for (int p = 1; p < 64; p++) begin
      if ($countones(p) != 1) begin
        if (k == j) return p;
        k++;
      end
    end
    return 0;
  endfunction

  function automatic logic [RW:0] encode(logic [DW-1:0] d);
    logic [RW:0] c = '0;
    for (int i = 0; i < RW; i++) begin
      for (int j = 0; j < DW; j++) begin
        int p = dpos(j);
        if ((p & (1 << i)) != 0) c[i] = c[i] ^ d[j];
      end
    end
    c[RW] = ^{d, c[RW-1:0]};
    return c;
  endfunction

  function automatic exp_t model(logic [DW-1:0] d, logic [RW:0] c, logic cor);
    exp_t        e;
    logic [RW:0] rc;
    int          s;
    bit          par;
    rc    = encode(d);
    e.syn = rc[RW-1:0] ^ c[RW-1:0];
    par   = ^{d, c};
    s     = int'(e.syn);
    e.dat = d;
    e.sec = 1'b0;
    e.ded = 1'b0;
    if (!par) e.ded = (s != 0);
    else if (s == 0 || $countones(s) == 1) e.sec = 1'b1;
    else if (s <= N) begin
      e.sec = 1'b1;
      if (cor) for (int j = 0; j < DW; j++) if (dpos(j) == s) e.dat[j] = ~d[j];
    end else e.ded = 1'b1;
    return e;
  endfunction

  // One clock: observe and score at the falling edge, then return just after the next rising edge.
  task automatic cyc();
    exp_t o;
    exp_t fe;
    ent_t en;
    bit   fire_ok;
    @(negedge clk);
    cyc_n++;
    acc_flag = 1'b0;
    fire_ok  = 1'b0;
    if (rst) begin
      q.delete();
      sec_m   = 0;
      ded_m   = 0;
      stalled = 1'b0;
    end else begin
      chk("in_ready", bus.in_ready, !(q.size() == 2 && !bus.out_ready));
      chk("sec_cnt", sec_cnt, sec_m);
      chk("ded_cnt", ded_cnt, ded_m);
      if (stalled) chk("stall_hold_valid", bus.out_valid, 1);
      if (bus.out_valid) begin
        o = {bus.out_data, bus.out_syn, bus.out_sec, bus.out_ded};
        if (q.size() == 0) chk("spurious_out", bus.out_valid, 0);
        else begin
          chk("out_word", o, q[0].e);
          if (bus.out_ready) begin
            if (strict) chk("latency", cyc_n - q[0].acc, 2);
            fe      = q[0].e;
            fire_ok = 1'b1;
            last    = o;
            void'(q.pop_front());
          end
        end
      end
      if (cnt_clr) begin
        sec_m = 0;
        ded_m = 0;
      end else if (fire_ok) begin
        if (fe.sec && sec_m < CMAX) sec_m++;
        if (fe.ded && ded_m < CMAX) ded_m++;
      end
      if (bus.in_valid && bus.in_ready) begin
        en.e   = model(bus.in_data, bus.in_check, cfg_correct);
        en.acc = cyc_n;
        q.push_back(en);
        acc_flag = 1'b1;
      end
      stalled = bus.out_valid & !bus.out_ready;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [DW-1:0] d, logic [RW:0] c, logic cor);
    int g = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_check = c;
    cfg_correct  = cor;
    do begin
      cyc();
      g++;
    end while (!acc_flag && g < 20);
    chk("send_accept", acc_flag, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (q.size() != 0 && g < 50) begin
      cyc();
      g++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic new_word();
    logic [DW-1:0] d;
    logic [N:0]    v;
    int            m;
    int            b1;
    int            b2;
    d  = DW'($urandom);
    v  = {encode(d), d};
    m  = $urandom_range(0, 3);
    b1 = $urandom_range(0, N);
    b2 = (b1 + $urandom_range(1, N)) % (N + 1);
    if (m >= 1) v[b1] = ~v[b1];
    if (m == 2) v[b2] = ~v[b2];
    if (m == 3) v[N:DW] = (RW + 1)'($urandom);
    bus.in_data  = v[DW-1:0];
    bus.in_check = v[N:DW];
    cfg_correct  = 1'($urandom);
    bus.in_valid = 1'b1;
  endtask

  task automatic stream(int n, bit pattern);
    int sent = 0;
    int k = 0;
    int g = 0;
    while ((sent < n || q.size() != 0) && g < 40 * n) begin
      if (!bus.in_valid && sent < n && (pattern || $urandom_range(0, 3) != 0)) new_word();
      bus.out_ready = pattern ? (k % 3 == 0) : ($urandom_range(0, 2) != 0);
      cnt_clr       = pattern ? 1'b0 : ($urandom_range(0, 19) == 0);
      cyc();
      k++;
      g++;
      if (acc_flag) begin
        sent++;
        bus.in_valid = 1'b0;
      end
    end
    cnt_clr = 1'b0;
    chk("stream_sent", sent, n);
    chk("stream_drained", q.size(), 0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_check  = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) cyc();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_syn", bus.out_syn, 0);
    chk("rst_out_flags", {bus.out_sec, bus.out_ded}, 0);
    chk("rst_cnts", {sec_cnt, ded_cnt}, 0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    cyc();
    chk("rst_in_ready", bus.in_ready, 1);

    strict = 1'b1;
    send(16'h0000, 6'h00, 1'b1);
    drain();
    chk("t1_clean", last, {16'h0000, 5'h00, 1'b0, 1'b0});
    send(16'h0001, 6'h00, 1'b1);
    drain();
    chk("t2_corrected", last, {16'h0000, 5'h03, 1'b1, 1'b0});
    chk("t2_sec_cnt", sec_cnt, 1);
    send(16'h0003, 6'h00, 1'b1);
    drain();
    chk("t3_double", last, {16'h0003, 5'h06, 1'b0, 1'b1});
    chk("t3_ded_cnt", ded_cnt, 1);
    send(16'h0001, 6'h00, 1'b0);
    drain();
    chk("t3_detect_only", last, {16'h0001, 5'h03, 1'b1, 1'b0});
    send(16'h0000, 6'h01, 1'b1);
    drain();
    chk("t4_check_bit", last, {16'h0000, 5'h01, 1'b1, 1'b0});
    send(16'h0000, 6'h20, 1'b1);
    drain();
    chk("t4_parity_bit", last, {16'h0000, 5'h00, 1'b1, 1'b0});
    send(16'h8000, 6'h00, 1'b1);
    drain();
    chk("top_data_bit", last, {16'h0000, 5'h15, 1'b1, 1'b0});
    send(16'h0000, 6'h3E, 1'b1);
    drain();
    chk("syn_out_of_range", last, {16'h0000, 5'h1E, 1'b0, 1'b1});
    strict = 1'b0;

    stream(8, 1'b1);
    stream(300, 1'b0);

    bus.out_ready = 1'b1;
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    chk("t6_clear", sec_cnt, 0);
    repeat (5) send(16'h0001, 6'h00, 1'b1);
    drain();
    chk("t6_saturate", sec_cnt, CMAX);
    bus.out_ready = 1'b0;
    send(16'h0001, 6'h00, 1'b1);
    repeat (2) cyc();
    chk("t6_held_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    chk("t6_clr_wins", sec_cnt, 0);

    bus.out_ready = 1'b0;
    send(16'h0001, 6'h00, 1'b1);
    send(16'h0003, 6'h00, 1'b1);
    chk("rst_pre_valid", bus.out_valid, 1);
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) begin
      cyc();
      chk("rst_flush", bus.out_valid, 0);
    end
    chk("rst_flush_cnts", {sec_cnt, ded_cnt}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
